// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit ALU command path.
//   - opcode constants OP_ADD..OP_MOD (cmd_op / alu_sel encoding)
//   - error codes ERR_OK, ERR_DIV0, ERR_ILLEGAL (rsp_err encoding)
//   - sequencer state enum
//   - small opcode classification helpers
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  // Anything outside the five defined operations is rejected.
  function automatic logic op_is_illegal(input logic [2:0] op);
    logic illegal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
    return illegal;
  endfunction

  // Operations whose result can be undefined for a zero divisor.
  function automatic logic op_is_divide(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Only add and sub produce a meaningful carry/borrow.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side initiator for the 4-bit ALU.
// Accepts a command over a valid/ready channel, screens illegal opcodes and
// divide/mod by zero, drives a registered operand/select bus to an external
// ALU, captures the result one cycle later and returns it over a valid/ready
// response channel. Keeps a wrapping completion counter and a saturating
// error counter.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op, cmd_a, cmd_b       opcode and 4-bit operands
//   alu_a, alu_b, alu_sel      registered ALU bus (held between issues)
//   alu_out, alu_carry         combinational ALU result and carry/borrow
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_carry, rsp_err  captured result, masked carry, error code
//   ops_done                   responses handed off (wraps)
//   err_count                  error responses handed off (saturates)
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic [1:0]       rsp_err,
  output logic [CNT_W-1:0] ops_done,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_e       state_q, state_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ADD;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      ops_done_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      ops_done_q  <= ops_done_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    ops_done_d  = ops_done_q;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Rejected commands go straight to RESP and never touch the ALU
          // bus, so the ALU inputs keep the last legal operation.
          if (op_is_illegal(cmd_op)) begin
            rsp_err_d   = ERR_ILLEGAL;
            rsp_data_d  = '0;
            rsp_carry_d = 1'b0;
            state_d     = ST_RESP;
          end else if (op_is_divide(cmd_op) && (cmd_b == 4'd0)) begin
            rsp_err_d   = ERR_DIV0;
            rsp_data_d  = '0;
            rsp_carry_d = 1'b0;
            state_d     = ST_RESP;
          end else begin
            alu_a_d   = cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_op;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // The ALU has had the whole cycle since the bus was loaded.
        rsp_data_d  = alu_out;
        rsp_carry_d = op_has_carry(alu_sel_q) ? alu_carry : 1'b0;
        rsp_err_d   = ERR_OK;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + CNT_ONE;
          if ((rsp_err_q != ERR_OK) && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode registered state only.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign ops_done  = ops_done_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a
// behavioural 4-bit ALU attached to the ALU bus.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [1:0] rsp_err;
  logic [7:0] ops_done;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .ops_done  (ops_done),
    .err_count (err_count)
  );

  // External ALU: 8-bit result, borrow flag on sub. Carry is driven high
  // for mul/div/mod so that the sequencer's masking is exercised.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_sel)
      OP_ADD: {alu_carry, alu_out} = {5'b0, alu_a} + {5'b0, alu_b};
      OP_SUB: begin
        alu_out   = {4'b0, alu_a} - {4'b0, alu_b};
        alu_carry = (alu_a < alu_b);
      end
      OP_MUL: begin
        alu_out   = {4'b0, alu_a} * {4'b0, alu_b};
        alu_carry = 1'b1;
      end
      OP_DIV: begin
        alu_out   = (alu_b == 4'd0) ? 8'hFF : {4'b0, alu_a / alu_b};
        alu_carry = 1'b1;
      end
      OP_MOD: begin
        alu_out   = (alu_b == 4'd0) ? 8'hFF : {4'b0, alu_a % alu_b};
        alu_carry = 1'b1;
      end
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_alu_bus"},   {alu_a, alu_b, alu_sel}, 0);
    check({tag, "_rsp"},       {rsp_data, rsp_carry, rsp_err}, 0);
    check({tag, "_ops_done"},  ops_done, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  // Present a command, wait for the response, check it, optionally hold
  // rsp_ready low for 'hold' cycles, then complete the handshake.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input int exp_lat, input logic [7:0] exp_data,
                       input logic exp_carry, input logic [1:0] exp_err, input int hold);
    int lat;
    logic [7:0] ops_before;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    lat = 0;
    while (!cmd_ready && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_accept"}, cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"},  rsp_data,  exp_data);
    check({tag, "_carry"}, rsp_carry, exp_carry);
    check({tag, "_err"},   rsp_err,   exp_err);
    ops_before = ops_done;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_data"},  {rsp_data, rsp_carry, rsp_err}, {exp_data, exp_carry, exp_err});
      check({tag, "_hold_ready"}, cmd_ready, 0);
      check({tag, "_hold_ops"},   ops_done, ops_before);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] av;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    // Add, sub with borrow, mul with carry masked
    do_op("add", OP_ADD, 4'd9, 4'd8, 2, 8'h11, 1'b0, ERR_OK, 0);
    @(negedge clk);
    check("add_ops_done", ops_done, 1);
    check("add_alu_bus", {alu_a, alu_b, alu_sel}, {4'd9, 4'd8, OP_ADD});
    check("add_cmd_ready", cmd_ready, 1);
    do_op("sub", OP_SUB, 4'd3, 4'd5, 2, 8'hFE, 1'b1, ERR_OK, 0);
    do_op("mul", OP_MUL, 4'd15, 4'd15, 2, 8'hE1, 1'b0, ERR_OK, 0);

    // Error screening: bus must keep the mul operands
    do_op("div0", OP_DIV, 4'd7, 4'd0, 1, 8'h00, 1'b0, ERR_DIV0, 0);
    @(negedge clk);
    check("div0_alu_bus", {alu_a, alu_b, alu_sel}, {4'd15, 4'd15, OP_MUL});
    check("div0_err_count", err_count, 1);
    check("div0_ops_done", ops_done, 4);
    do_op("ill", 3'b110, 4'd1, 4'd2, 1, 8'h00, 1'b0, ERR_ILLEGAL, 0);
    @(negedge clk);
    check("ill_err_count", err_count, 2);
    check("ill_alu_sel", alu_sel, OP_MUL);
    do_op("mod0", OP_MOD, 4'd9, 4'd0, 1, 8'h00, 1'b0, ERR_DIV0, 0);
    do_op("div", OP_DIV, 4'd14, 4'd3, 2, 8'h04, 1'b0, ERR_OK, 0);

    // Backpressure
    do_op("bp", OP_MOD, 4'd13, 4'd4, 2, 8'h01, 1'b0, ERR_OK, 5);
    @(negedge clk);
    check("bp_ops_done", ops_done, 8);
    check("bp_err_count", err_count, 3);
    check("bp_cmd_ready", cmd_ready, 1);

    // Reset during ISSUE discards the op
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 4'd5; cmd_b = 4'd5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_in_issue", {cmd_ready, rsp_valid}, 2'b00);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    repeat (3) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 0);
    end
    do_op("post_rst", OP_ADD, 4'd1, 4'd1, 2, 8'h02, 1'b0, ERR_OK, 0);

    // ops_done wrap: 255 more legal ops after the one above
    for (int i = 0; i < 255; i++) begin
      av = 4'(i);
      do_op("wrap", OP_ADD, av, 4'd3, 2, {4'b0, av} + 8'd3, 1'b0, ERR_OK, 0);
      if (i == 253) begin
        @(negedge clk);
        check("wrap_pre", ops_done, 8'hFF);
      end
    end
    @(negedge clk);
    check("wrap_ops_done", ops_done, 0);
    check("wrap_err_count", err_count, 0);

    // err_count saturation: 300 error ops, alternating kinds
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0)
        do_op("sat", 3'b111, 4'd0, 4'd0, 1, 8'h00, 1'b0, ERR_ILLEGAL, 0);
      else
        do_op("sat", OP_DIV, 4'd5, 4'd0, 1, 8'h00, 1'b0, ERR_DIV0, 0);
      if (i == 253) begin
        @(negedge clk);
        check("sat_pre", err_count, 8'd254);
      end
    end
    @(negedge clk);
    check("sat_err_count", err_count, 8'hFF);
    check("sat_ops_done", ops_done, 8'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 4-bit arithmetic ALU. Accepts operation requests over a valid/ready command channel and drives the ALU operand/select bus. Captures the ALU result one cycle later and returns it over a valid/ready response channel. Screens divide/modulus-by-zero and undefined opcodes before they reach the ALU, and keeps completion and error counters for software visibility.

## Interface
Parameters:
- CNT_W, 8, width of the `ops_done` and `err_count` counters

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode:
  - 000 add
  - 001 sub
  - 010 mul
  - 011 div
  - 100 mod
  - 101–111 illegal
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- alu_a  out  4  registered operand A to the ALU
- alu_b  out  4  registered operand B to the ALU
- alu_sel  out  3  registered opcode to the ALU
- alu_out  in  8  ALU result (combinational from `alu_a`, `alu_b`, `alu_sel`)
- alu_carry  in  1  ALU carry/borrow; meaningful only for add and sub
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  captured result
- rsp_carry  out  1  captured carry, masked to 0 for ops other than add/sub
- rsp_err  out  2  error code:
  - 00 ok
  - 01 divide/mod by zero
  - 10 illegal opcode
- ops_done  out  CNT_W  responses handed off, wraps
- err_count  out  CNT_W  error responses handed off, saturates at all-ones

## Operation
States: IDLE, ISSUE, RESP.

- **IDLE:** `cmd_ready`=1. On `cmd_valid`&`cmd_ready`:
  - Opcode 101–111 → RESP with `rsp_err`=10, `rsp_data`=0, `rsp_carry`=0. ALU bus not updated.
  - Opcode 011/100 with `cmd_b`=0 → RESP with `rsp_err`=01, `rsp_data`=0, `rsp_carry`=0. ALU bus not updated.
  - Otherwise → ISSUE; `alu_a`/`alu_b`/`alu_sel` load `cmd_a`/`cmd_b`/`cmd_op`.
- **ISSUE:** at the end of the cycle:
  - `rsp_data` ← `alu_out`.
  - `rsp_carry` ← `alu_carry` if `alu_sel` is 000/001, else 0.
  - `rsp_err` ← 00.
  - Next state RESP.
- **RESP:** `rsp_valid`=1. `rsp_data`/`rsp_carry`/`rsp_err` held stable until `rsp_ready`. On `rsp_valid`&`rsp_ready`:
  - `ops_done` increments, wrapping.
  - If `rsp_err`≠00, `err_count` increments, saturating.
  - Next state IDLE.
- `cmd_ready`=0 in ISSUE and RESP. Commands are never dropped; the requester holds them.
- The ALU bus holds its last issued value outside ISSUE, so the ALU input never toggles spuriously.

Reset (`rst_n`=0 at a clock edge, any state, including mid-ISSUE or mid-RESP):
- State → IDLE.
- `alu_a`=0, `alu_b`=0, `alu_sel`=000.
- `rsp_data`=0, `rsp_carry`=0, `rsp_err`=00, `rsp_valid`=0.
- `ops_done`=0, `err_count`=0.
- `cmd_ready` is 1 from the first cycle after reset is released.
- An in-flight operation is discarded with no response.

## Timing
- Command accepted at edge N, legal op: ALU bus valid after edge N; result captured at edge N+1; `rsp_valid` high after edge N+1.
- Error op accepted at edge N: `rsp_valid` high after edge N.
- Handshake at edge M (`rsp_valid`&`rsp_ready`): counters update at edge M; `cmd_ready` high after edge M.
- Maximum throughput: one legal op per 3 cycles, one error op per 2 cycles.
- `cmd_ready` and `rsp_valid` are decoded from registered state only, with no combinational path from `cmd_valid` or `rsp_ready`.
- The ALU path (`alu_a`/`alu_b`/`alu_sel` → `alu_out`) gets one full cycle.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants (`OP_ADD`..`OP_MOD`)
  - error codes (`ERR_OK`, `ERR_DIV0`, `ERR_ILLEGAL`)
  - the sequencer state enum
- Single module. The ALU is instantiated alongside it by the parent, not inside it. No sub-module is warranted.

## Test plan
- **Add:** cmd add A=9 B=8 → `rsp_data`=0x11, `rsp_carry`=0, `rsp_err`=00, `rsp_valid` 2 cycles after accept; `ops_done`=1.
- **Sub with borrow:** cmd sub A=3 B=5 → `rsp_data`=0xFE, `rsp_carry`=1. Then mul A=15 B=15 → `rsp_data`=0xE1, `rsp_carry`=0.
- **Error screening:**
  - div A=7 B=0 → `rsp_err`=01, `rsp_data`=0, `alu_sel` unchanged from previous op, `err_count`=1.
  - Opcode 110 → `rsp_err`=10, `err_count`=2.
- **Backpressure:** cmd mod A=13 B=4, hold `rsp_ready`=0 for 5 cycles → `rsp_data`=0x01 stable throughout, `cmd_ready`=0 throughout; counters change only on the handshake edge.
- **Reset mid-op:** assert `rst_n`=0 for 1 edge during ISSUE → no response. All outputs hit reset values, `cmd_ready`=1 next cycle, and the next add 1+1 returns 0x02.
- **Counter boundaries:** 256 legal ops → `ops_done` wraps to 0. 300 error ops → `err_count` sticks at 0xFF.
